// File: rtl/div_32_5_arb.sv
// Round-robin share of one constant divide-by-5 datapath among NREQ requesters, LAT cycles request to response.
// A held response (resp_valid && !resp_ready) freezes every stage; optional remainder output under DIV_REM_EN.

module div_32_5 (
  input  logic [31:0] x,
  output logic [29:0] q
`ifdef DIV_REM_EN
  ,
  output logic [2:0]  r
`endif
);
  logic [33:0] prod_unused;

  // Exact floor(x/5) for every 32-bit x: multiply by ceil(2^34/5) and keep bits above 34.
  assign {q, prod_unused} = {32'd0, x} * 64'h0000_0000_CCCC_CCCD;

`ifdef DIV_REM_EN
  logic [28:0] rem_unused;
  assign {rem_unused, r} = x - {q, 2'b00} - {2'b00, q};
`endif
endmodule

module div_32_5_arb #(
  parameter  int NREQ = 4,
  parameter  int LAT  = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [29:0]          resp_q,
`ifdef DIV_REM_EN
  output logic [2:0]           resp_r,
`endif
  input  logic                 resp_ready,
  output logic                 busy
);
  localparam int NOUT = LAT - 1;

  logic            adv;
  logic            hs;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  idx;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            s1_vld_q, s1_vld_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic [31:0]     s1_x_q, s1_x_d;

  logic [29:0]     div_q;
  logic            o_vld_q [NOUT];
  logic [IDW-1:0]  o_id_q  [NOUT];
  logic [29:0]     o_q_q   [NOUT];
`ifdef DIV_REM_EN
  logic [2:0]      div_r;
  logic [2:0]      o_r_q   [NOUT];
`endif

  assign adv = !o_vld_q[NOUT-1] || resp_ready;

  // Scan offsets from the top down so the requester closest above ptr is the last (winning) write.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (req_valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gnt_id     = idx;
      end
    end
  end

  assign req_ready = (adv && !rst) ? grant : '0;
  assign hs        = |req_ready;

  always_comb begin
    ptr_d    = ptr_q;
    s1_vld_d = s1_vld_q;
    s1_id_d  = s1_id_q;
    s1_x_d   = s1_x_q;
    if (adv) begin
      s1_vld_d = hs;
      if (hs) begin
        ptr_d   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
        s1_id_d = gnt_id;
        s1_x_d  = req_x[32*gnt_id +: 32];
      end
    end
  end

  div_32_5 u_div (
    .x (s1_x_q),
    .q (div_q)
`ifdef DIV_REM_EN
    ,
    .r (div_r)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_id_q  <= '0;
      s1_x_q   <= '0;
      for (int k = 0; k < NOUT; k++) begin
        o_vld_q[k] <= 1'b0;
        o_id_q[k]  <= '0;
        o_q_q[k]   <= '0;
`ifdef DIV_REM_EN
        o_r_q[k]   <= '0;
`endif
      end
    end else begin
      ptr_q    <= ptr_d;
      s1_vld_q <= s1_vld_d;
      s1_id_q  <= s1_id_d;
      s1_x_q   <= s1_x_d;
      if (adv) begin
        o_vld_q[0] <= s1_vld_q;
        o_id_q[0]  <= s1_id_q;
        o_q_q[0]   <= div_q;
`ifdef DIV_REM_EN
        o_r_q[0]   <= div_r;
`endif
        for (int k = 1; k < NOUT; k++) begin
          o_vld_q[k] <= o_vld_q[k-1];
          o_id_q[k]  <= o_id_q[k-1];
          o_q_q[k]   <= o_q_q[k-1];
`ifdef DIV_REM_EN
          o_r_q[k]   <= o_r_q[k-1];
`endif
        end
      end
    end
  end

  always_comb begin
    busy = s1_vld_q;
    for (int k = 0; k < NOUT; k++) begin
      busy = busy | o_vld_q[k];
    end
  end

  assign resp_valid = o_vld_q[NOUT-1];
  assign resp_id    = o_id_q[NOUT-1];
  assign resp_q     = o_q_q[NOUT-1];
`ifdef DIV_REM_EN
  assign resp_r     = o_r_q[NOUT-1];
`endif
endmodule

// File: tb/tb_div_32_5_arb.sv
// Directed and random bench for div_32_5_arb against a slot-array reference model.
module tb_div_32_5_arb;
  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int IDW  = $clog2(NREQ);

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_x;
  logic [NREQ-1:0]     req_ready;
  logic                resp_valid;
  logic [IDW-1:0]      resp_id;
  logic [29:0]         resp_q;
`ifdef DIV_REM_EN
  logic [2:0]          resp_r;
`endif
  logic                resp_ready;
  logic                busy;

  div_32_5_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_q     (resp_q),
`ifdef DIV_REM_EN
    .resp_r     (resp_r),
`endif
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: LAT slots from acceptance (slot 0) to the response port (slot LAT-1).
  bit          m_v  [LAT];
  int          m_id [LAT];
  logic [31:0] m_x  [LAT];
  int          m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < LAT; k++) begin
      m_v[k]  = 1'b0;
      m_id[k] = 0;
      m_x[k]  = '0;
    end
    m_ptr = 0;
  endtask

  task automatic set_x(input int i, input logic [31:0] v);
    req_x[32*i +: 32] = v;
  endtask

  // Called at a falling edge with inputs already driven; checks outputs, then advances one cycle.
  task automatic step();
    int              g;
    bit              adv;
    bit              any;
    logic [NREQ-1:0] exp_rdy;
    #1;
    adv     = !m_v[LAT-1] || resp_ready;
    g       = exp_grant(req_valid, m_ptr);
    exp_rdy = '0;
    if (!rst && adv && g >= 0) exp_rdy[g] = 1'b1;
    any = 1'b0;
    for (int k = 0; k < LAT; k++) any = any | m_v[k];
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("resp_valid", 64'(resp_valid), 64'(m_v[LAT-1]));
    chk("busy", 64'(busy), 64'(any));
    if (m_v[LAT-1]) begin
      chk("resp_id", 64'(resp_id), 64'(m_id[LAT-1]));
      chk("resp_q", 64'(resp_q), 64'(m_x[LAT-1] / 32'd5));
`ifdef DIV_REM_EN
      chk("resp_r", 64'(resp_r), 64'(m_x[LAT-1] % 32'd5));
`endif
    end
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else if (adv) begin
      for (int k = LAT - 1; k > 0; k--) begin
        m_v[k]  = m_v[k-1];
        m_id[k] = m_id[k-1];
        m_x[k]  = m_x[k-1];
      end
      m_v[0] = (g >= 0);
      if (g >= 0) begin
        m_id[0] = g;
        m_x[0]  = req_x[32*g +: 32];
        m_ptr   = (g + 1) % NREQ;
      end
    end
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_x      = '0;
    resp_ready = 1'b1;
    model_clear();
    @(negedge clk);

    // Reset state, including req_ready held low while rst is high.
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_q", 64'(resp_q), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
`ifdef DIV_REM_EN
    chk("rst_resp_r", 64'(resp_r), 64'd0);
`endif
    req_valid = '1;
    step();
    rst       = 1'b0;
    req_valid = '0;

    // Single request.
    req_valid = 4'b0001;
    set_x(0, 32'd1234567);
    step();
    req_valid = '0;
    steps(3);

    // Extremes back-to-back from requester 2.
    req_valid = 4'b0100;
    set_x(2, 32'hFFFF_FFFF);
    step();
    set_x(2, 32'd4);
    step();
    req_valid = '0;
    steps(3);

    // All requesters continuously valid.
    for (int i = 0; i < NREQ; i++) set_x(i, 32'(100 + i));
    req_valid = '1;
    steps(9);
    req_valid = '0;
    steps(3);

    // Fairness between requesters 1 and 3, starting from ptr = 0.
    rst = 1'b1;
    step();
    rst       = 1'b0;
    req_valid = 4'b1010;
    set_x(1, 32'd55);
    set_x(3, 32'd77);
    steps(6);
    req_valid = '0;
    steps(3);

    // Backpressure on a full pipeline.
    req_valid = '1;
    steps(3);
    resp_ready = 1'b0;
    steps(3);
    resp_ready = 1'b1;
    req_valid  = '0;
    steps(4);

    // Reset with two entries in flight, then a fresh request.
    req_valid = 4'b0001;
    set_x(0, 32'd999);
    steps(2);
    req_valid = '0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    steps(3);
    req_valid = 4'b0001;
    set_x(0, 32'd10);
    step();
    req_valid = '0;
    steps(3);

    // Random traffic with random backpressure and occasional resets.
    for (int c = 0; c < 600; c++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 7))
          0:       set_x(i, 32'hFFFF_FFFF);
          1:       set_x(i, 32'($urandom_range(0, 9)));
          default: set_x(i, $urandom);
        endcase
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 63) == 0);
      step();
    end
    rst        = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    steps(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/div_32_5_arb.md
# div_32_5_arb

Round-robin scheduler that shares one constant divide-by-5 datapath (32-bit dividend, 30-bit quotient) between NREQ requesters. It arbitrates valid/ready request ports, pushes one dividend per cycle into an internal registered pipeline around the `div_32_5` core, and tags every result with the winning requester's ID. A single response port with backpressure carries each result out. The block sits between client engines and the divider; it is the only user of the `div_32_5` instance.

## Interface
- NREQ, 4, number of requesters (2..16)
- LAT, 2, request-to-response latency in cycles (>=2): input register stage plus LAT-1 output register stages
- IDW, $clog2(NREQ), requester ID width (derived, do not override)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  per-requester request valid
- req_x  in  32*NREQ  dividends, requester i at bits [32*i+31:32*i]
- req_ready  out  NREQ  one-hot grant/accept, at most one bit high
- resp_valid  out  1  result valid
- resp_id  out  IDW  requester that issued the result
- resp_q  out  30  floor(X/5)
- resp_r  out  3  X mod 5 (present only with DIV_REM_EN)
- resp_ready  in  1  consumer accepts result
- busy  out  1  any pipeline stage holds a valid entry

## Operation
- adv = !last_stage_valid || resp_ready. When adv is 0, all stages freeze and no request is accepted.
- Arbiter: search starts at pointer ptr and runs upward modulo NREQ. The first i with req_valid[i] is granted. req_ready[i] = adv && grant[i] && !rst.
- Handshake on req i sets ptr <= (i+1) mod NREQ. With no handshake, ptr holds.
- On handshake, stage 1 captures {valid=1, id=i, x=req_x[i]}. Stage 1 feeds the combinational `div_32_5`. The quotient, the id and (with the macro) the remainder advance through LAT-1 registers.
- A cycle with adv=1 and no grant inserts a bubble (valid=0). Bubbles are not collapsed.
- Arithmetic:
  - Q = floor(X/5). The maximum is 858993459, which fits 30 bits.
  - R = X - 5*Q, range 0..4. Compute it from 32-bit X and Q, truncate to 3 bits.
- Outputs come straight from the last stage registers. resp_q/resp_id/resp_r hold stable while resp_valid && !resp_ready.
- Responses leave in acceptance order. No reordering, no drops.
- busy = OR of all stage valid bits.

## Timing
- Reset (rst high at an edge):
  - All stage valids 0 and ptr 0.
  - resp_valid=0, resp_id=0, resp_q=0, resp_r=0, busy=0.
  - req_ready=0 while rst is high.
- Reset mid-operation discards all in-flight entries. No response is ever produced for them.
- Latency: a handshake in cycle c gives resp_valid in cycle c+LAT, provided adv stays 1.
- Throughput: one request per cycle sustained with resp_ready=1.
- Simultaneous resp handshake and new grant in the same cycle is legal; the pipeline advances by one.
- resp_ready low with a valid last stage stalls everything, including stage 1. req_ready is 0 that cycle.
- ptr wraps from NREQ-1 to 0.

## Configuration
- DIV_REM_EN defined:
  - resp_r port exists.
  - Remainder is computed at the divider stage and pipelined alongside Q.
- DIV_REM_EN undefined:
  - resp_r port and remainder logic/registers are absent.
  - Quotient, ID and timing are unchanged.

## Test plan
- Single request: req0 X=1234567, resp_ready=1 -> after 2 cycles resp_valid=1, id=0, Q=246913, R=2; busy falls next cycle.
- Extremes: X=32'hFFFFFFFF then X=4 from req2 back-to-back -> Q=858993459 R=0, then Q=0 R=4, id=2 both, consecutive cycles.
- All requesters valid continuously, X=100,101,102,103 for req0..3 -> grants 0,1,2,3,0,…; responses Q=20 each, R=0,1,2,3 in that order.
- Fairness: only req1 and req3 valid continuously from ptr=0 -> grants alternate 1,3,1,3; neither waits more than 1 cycle.
- Backpressure: pipeline full, resp_ready low 3 cycles -> resp fields held stable, req_ready=0, no loss; results drain in order once resp_ready rises.
- Reset mid-flight: 2 entries in flight, rst high 1 cycle -> resp_valid=0, busy=0, ptr=0; no stale response afterward; next req0 X=10 returns Q=2 after LAT cycles.
